mips_main_control: RTL and testbench

Multicycle main control FSM for the MIPS core. Sequences the shared datapath (PC register, unified instruction/data memory, register file, ALU) one instruction at a time. It drives the PC write enables `pcWrite` and `pcWriteCond`; the PC block combines `pcWriteCond` with the ALU `zero` flag. It honours a memory-ready handshake and counts retired instructions.

---
 rtl/mips_pkg.sv | 41 ++++
 rtl/mips_main_control.sv | 156 +++++++++++++++
 tb/tb_mips_main_control.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM states
// and the datapath mux/ALU select codes.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EX   = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_TRAP      = 4'd12
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  localparam logic [1:0] SRCB_B     = 2'd0;
  localparam logic [1:0] SRCB_FOUR  = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_SHIMM = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/mips_main_control.sv
// Multicycle MIPS main control: Moore FSM sequencing the shared datapath one
// instruction at a time, with a memory-ready handshake and a retire counter.
module mips_main_control
  import mips_pkg::*;
#(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               memReady,
  output logic               pcWrite,
  output logic               pcWriteCond,
  output logic               iOrD,
  output logic               memRead,
  output logic               memWrite,
  output logic               irWrite,
  output logic               regDst,
  output logic               memToReg,
  output logic               regWrite,
  output logic               aluSrcA,
  output logic [1:0]         aluSrcB,
  output logic [1:0]         aluOp,
  output logic [1:0]         pcSource,
  output logic               illegalOp,
  output logic [3:0]         state,
  output logic [COUNT_W-1:0] instrCount
);

  state_t             r_state;
  state_t             w_next;
  logic [COUNT_W-1:0] r_count;
  logic               w_retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_count <= r_count + 1'b1;
    end
  end

  // An instruction retires on the edge that returns the FSM to FETCH from any
  // completing state; TRAP returns without retiring.
  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP, S_ADDI_WB: w_retire = 1'b1;
      S_MEM_WRITE:                                      w_retire = memReady;
      default:                                          w_retire = 1'b0;
    endcase
  end

  always_comb begin
    w_next      = r_state;
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    iOrD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    regDst      = 1'b0;
    memToReg    = 1'b0;
    regWrite    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = SRCB_B;
    aluOp       = ALUOP_ADD;
    pcSource    = PCSRC_ALU;
    illegalOp   = 1'b0;
    case (r_state)
      S_FETCH: begin
        memRead = 1'b1;
        aluSrcB = SRCB_FOUR;
        // PC/IR load only on the completing fetch cycle, never while in reset.
        if (memReady && rst_n) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
        end
        if (memReady) w_next = S_DECODE;
      end
      S_DECODE: begin
        aluSrcB = SRCB_SHIMM;
        case (opcode)
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_ADDI_EX;
          default:      w_next = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
        w_next  = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        memRead = 1'b1;
        iOrD    = 1'b1;
        if (memReady) w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        regWrite = 1'b1;
        memToReg = 1'b1;
        w_next   = S_FETCH;
      end
      S_MEM_WRITE: begin
        memWrite = 1'b1;
        iOrD     = 1'b1;
        if (memReady) w_next = S_FETCH;
      end
      S_EXECUTE: begin
        aluSrcA = 1'b1;
        aluOp   = ALUOP_FUNCT;
        w_next  = S_ALU_WB;
      end
      S_ALU_WB: begin
        regWrite = 1'b1;
        regDst   = 1'b1;
        w_next   = S_FETCH;
      end
      S_BRANCH: begin
        aluSrcA     = 1'b1;
        aluOp       = ALUOP_SUB;
        pcWriteCond = 1'b1;
        pcSource    = PCSRC_ALUOUT;
        w_next      = S_FETCH;
      end
      S_JUMP: begin
        pcWrite  = 1'b1;
        pcSource = PCSRC_JUMP;
        w_next   = S_FETCH;
      end
      S_ADDI_EX: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
        w_next  = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        regWrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_TRAP: begin
        illegalOp = 1'b1;
        w_next    = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  assign state      = r_state;
  assign instrCount = r_count;

endmodule

// File: tb/tb_mips_main_control.sv
// Self-checking bench for mips_main_control: directed instructions plus random
// instruction/wait-state streams against a per-instruction state-sequence model.
module tb_mips_main_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opcode = 6'h00;
  logic        memReady = 1'b0;
  logic        pcWrite, pcWriteCond, iOrD, memRead, memWrite, irWrite;
  logic        regDst, memToReg, regWrite, aluSrcA, illegalOp;
  logic [1:0]  aluSrcB, aluOp, pcSource;
  logic [3:0]  state;
  logic [31:0] instrCount;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_count = 0;

  always #5 clk = ~clk;

  mips_main_control #(.COUNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .memReady(memReady),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iOrD(iOrD),
    .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
    .regDst(regDst), .memToReg(memToReg), .regWrite(regWrite),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
    .pcSource(pcSource), .illegalOp(illegalOp), .state(state),
    .instrCount(instrCount)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Order: pcWrite pcWriteCond iOrD memRead memWrite irWrite regDst memToReg
  //        regWrite aluSrcA aluSrcB aluOp pcSource illegalOp
  function automatic logic [16:0] pack_ctrl(
      bit pw, bit pwc, bit iod, bit mr, bit mw, bit irw, bit rd, bit m2r,
      bit rw, bit asa, bit [1:0] asb, bit [1:0] aop, bit [1:0] psrc, bit ill);
    return {pw, pwc, iod, mr, mw, irw, rd, m2r, rw, asa, asb, aop, psrc, ill};
  endfunction

  function automatic logic [16:0] exp_ctrl(int st, bit rdy, bit rn);
    case (st)
      0:  return pack_ctrl(rdy & rn, 0, 0, 1, 0, rdy & rn, 0, 0, 0, 0, 2'd1, 2'd0, 2'd0, 0);
      1:  return pack_ctrl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd3, 2'd0, 2'd0, 0);
      2:  return pack_ctrl(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 2'd0, 0);
      3:  return pack_ctrl(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0);
      4:  return pack_ctrl(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'd0, 2'd0, 2'd0, 0);
      5:  return pack_ctrl(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0);
      6:  return pack_ctrl(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd2, 2'd0, 0);
      7:  return pack_ctrl(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'd0, 2'd0, 2'd0, 0);
      8:  return pack_ctrl(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd1, 2'd1, 0);
      9:  return pack_ctrl(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd2, 0);
      10: return pack_ctrl(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 2'd0, 0);
      11: return pack_ctrl(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 0);
      12: return pack_ctrl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 1);
      default: return '0;
    endcase
  endfunction

  function automatic logic [16:0] dut_ctrl();
    return {pcWrite, pcWriteCond, iOrD, memRead, memWrite, irWrite, regDst,
            memToReg, regWrite, aluSrcA, aluSrcB, aluOp, pcSource, illegalOp};
  endfunction

  // Runs one instruction from FETCH back to FETCH. Caller is just after a
  // rising edge with the DUT in FETCH. Returns the cycle count taken.
  task automatic run_instr(input logic [5:0] op, input int wf, input int wm,
                           output int ncyc);
    int  st_q[$];
    bit  rdy_q[$];
    bit  retire;
    for (int i = 0; i < wf; i++) begin st_q.push_back(0); rdy_q.push_back(0); end
    st_q.push_back(0); rdy_q.push_back(1);
    st_q.push_back(1); rdy_q.push_back($urandom_range(0, 1));
    retire = 1;
    case (op)
      6'h00: begin
        st_q.push_back(6); rdy_q.push_back($urandom_range(0, 1));
        st_q.push_back(7); rdy_q.push_back($urandom_range(0, 1));
      end
      6'h23: begin
        st_q.push_back(2); rdy_q.push_back($urandom_range(0, 1));
        for (int i = 0; i < wm; i++) begin st_q.push_back(3); rdy_q.push_back(0); end
        st_q.push_back(3); rdy_q.push_back(1);
        st_q.push_back(4); rdy_q.push_back($urandom_range(0, 1));
      end
      6'h2B: begin
        st_q.push_back(2); rdy_q.push_back($urandom_range(0, 1));
        for (int i = 0; i < wm; i++) begin st_q.push_back(5); rdy_q.push_back(0); end
        st_q.push_back(5); rdy_q.push_back(1);
      end
      6'h04: begin st_q.push_back(8); rdy_q.push_back($urandom_range(0, 1)); end
      6'h02: begin st_q.push_back(9); rdy_q.push_back($urandom_range(0, 1)); end
      6'h08: begin
        st_q.push_back(10); rdy_q.push_back($urandom_range(0, 1));
        st_q.push_back(11); rdy_q.push_back($urandom_range(0, 1));
      end
      default: begin
        st_q.push_back(12); rdy_q.push_back($urandom_range(0, 1));
        retire = 0;
      end
    endcase
    opcode = op;
    ncyc = st_q.size();
    for (int i = 0; i < st_q.size(); i++) begin
      memReady = rdy_q[i];
      @(negedge clk);
      check($sformatf("state op=%0h cyc=%0d", op, i), 32'(state), 32'(st_q[i]));
      check($sformatf("ctrl op=%0h st=%0d", op, st_q[i]), 32'(dut_ctrl()),
            32'(exp_ctrl(st_q[i], rdy_q[i], 1'b1)));
      @(posedge clk); #1;
    end
    if (retire) exp_count = exp_count + 1;
    check($sformatf("back_to_fetch op=%0h", op), 32'(state), 32'd0);
    check($sformatf("instrCount op=%0h", op), instrCount, exp_count);
  endtask

  initial begin
    int n;
    logic [5:0] op;
    logic [5:0] legal [6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};

    // Reset with memReady high: FETCH decode, PC/IR loads suppressed.
    memReady = 1'b1;
    #3;
    check("reset_state", 32'(state), 32'd0);
    check("reset_count", instrCount, 32'd0);
    check("reset_ctrl", 32'(dut_ctrl()), 32'(exp_ctrl(0, 1'b0, 1'b0)));
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    run_instr(6'h00, 0, 0, n);
    check("rtype_cycles", n, 4);
    run_instr(6'h23, 2, 2, n);
    check("lw_wait_cycles", n, 9);
    run_instr(6'h2B, 0, 0, n);
    check("sw_cycles", n, 4);
    run_instr(6'h04, 0, 0, n);
    check("beq_cycles", n, 3);
    run_instr(6'h02, 0, 0, n);
    check("j_cycles", n, 3);
    check("count_after_directed", instrCount, 32'd5);
    run_instr(6'h3F, 0, 0, n);
    check("trap_cycles", n, 3);
    run_instr(6'h08, 0, 0, n);
    check("addi_cycles", n, 4);
    run_instr(6'h23, 0, 0, n);
    check("lw_cycles", n, 5);

    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        do op = 6'($urandom_range(0, 63));
        while (op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08});
      end else begin
        op = legal[$urandom_range(0, 5)];
      end
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), n);
    end

    // Abandon an lw while waiting in MEM_READ.
    opcode = 6'h23;
    memReady = 1'b1;
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    memReady = 1'b0;
    @(negedge clk);
    check("pre_reset_memread", 32'(state), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_state", 32'(state), 32'd0);
    check("async_reset_count", instrCount, 32'd0);
    memReady = 1'b1;
    #1;
    check("reset_ctrl_rdy", 32'(dut_ctrl()), 32'(exp_ctrl(0, 1'b0, 1'b0)));
    @(posedge clk); #1;
    memReady = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_reset_hold_state", 32'(state), 32'd0);
      check("post_reset_no_regwrite", 32'(regWrite), 32'd0);
      @(posedge clk); #1;
    end
    exp_count = 0;
    run_instr(6'h00, 1, 0, n);
    check("count_after_reset", instrCount, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
